// File: rtl/core_mau_if.sv
// Data-bus handshake between the memory access unit (master) and the data memory/fabric (slave).
interface core_mau_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata,
        input  dbus_ack, dbus_rdata, dbus_err
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
        output dbus_ack, dbus_rdata, dbus_err
    );
endinterface

// File: rtl/core_mau.sv
// Memory access unit: runs EX-stage loads/stores on the data bus, stalls the pipe while
// an access is outstanding and reports misaligned, bus-error and timeout faults.
module core_mau #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ld_i,
    input  logic        req_st_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        mau_halt_o,
    output logic [31:0] mau_data_o,
    output logic        mau_fault_o,
    output logic [1:0]  mau_fault_cause_o,
    output logic [31:0] mau_fault_addr_o,
    core_mau_if.master  dbus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] C_MISALIGN = 2'd1;
    localparam logic [1:0] C_BUSERR   = 2'd2;
    localparam logic [1:0] C_TIMEOUT  = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] faddr_q, faddr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cancel_q, cancel_d;

    logic accept;
    logic cancel;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        cause_d  = cause_q;
        faddr_d  = faddr_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;

        accept = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                 (req_ld_i || req_st_i) && !stall_i && !flush_i;
        // A flush arriving in the completing cycle cancels just like an earlier one.
        cancel = cancel_q || flush_i;

        case (state_q)
            S_BUSY: begin
                if (dbus.dbus_err) begin
                    req_d = 1'b0;
                    if (cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAULT;
                        cause_d = C_BUSERR;
                        faddr_d = addr_q;
                    end
                end else if (dbus.dbus_ack) begin
                    req_d = 1'b0;
                    if (cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (!we_q) begin
                            data_d = dbus.dbus_rdata;
                        end
                    end
                end else if (cnt_q == TMO_LAST) begin
                    req_d = 1'b0;
                    if (cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAULT;
                        cause_d = C_TIMEOUT;
                        faddr_d = addr_q;
                    end
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    cancel_d = cancel;
                end
            end
            default: begin
                if (accept) begin
                    if (req_addr_i[1:0] == 2'b00) begin
                        state_d  = S_BUSY;
                        req_d    = 1'b1;
                        we_d     = req_st_i;
                        addr_d   = req_addr_i;
                        wdata_d  = req_wdata_i;
                        cnt_d    = '0;
                        cancel_d = 1'b0;
                    end else begin
                        state_d = S_FAULT;
                        cause_d = C_MISALIGN;
                        faddr_d = req_addr_i;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            cause_q  <= '0;
            faddr_q  <= '0;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            cause_q  <= cause_d;
            faddr_q  <= faddr_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
        end
    end

    assign mau_halt_o        = (state_q == S_BUSY);
    assign mau_fault_o       = (state_q == S_FAULT);
    assign mau_data_o        = data_q;
    assign mau_fault_cause_o = cause_q;
    assign mau_fault_addr_o  = faddr_q;

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wdata = wdata_q;

endmodule

// File: tb/tb_core_mau.sv
// Directed bench for core_mau: a scoreboard queue holds the expected outcome of each
// accepted access and a negedge monitor pops it when the access completes or faults.
module tb_core_mau;

    logic        clk;
    logic        rst;
    logic        req_ld, req_st, stall, flush;
    logic [31:0] req_addr, req_wdata;
    logic        mau_halt, mau_fault;
    logic [31:0] mau_data, mau_fault_addr;
    logic [1:0]  mau_fault_cause;

    core_mau_if bus ();

    core_mau #(.TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_ld_i          (req_ld),
        .req_st_i          (req_st),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .stall_i           (stall),
        .flush_i           (flush),
        .mau_halt_o        (mau_halt),
        .mau_data_o        (mau_data),
        .mau_fault_o       (mau_fault),
        .mau_fault_cause_o (mau_fault_cause),
        .mau_fault_addr_o  (mau_fault_addr),
        .dbus              (bus)
    );

    typedef struct {
        bit          fault;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_data = '0;
    logic        prev_halt = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit f, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.fault = f; e.cause = c; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_halt = 1'b0;
        end else begin
            if (mau_fault || (prev_halt && !mau_halt)) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_fault", 32'(mau_fault), 32'(e.fault));
                    if (e.fault) begin
                        check("sb_cause", 32'(mau_fault_cause), 32'(e.cause));
                        check("sb_faddr", mau_fault_addr, e.addr);
                    end
                    check("sb_data", mau_data, e.data);
                end
            end
            prev_halt = mau_halt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_ld = 0; req_st = 0; stall = 0; flush = 0;
        req_addr = '0; req_wdata = '0;
        bus.dbus_ack = 0; bus.dbus_err = 0; bus.dbus_rdata = '0;
        step(); step();
        check("rst_req", 32'(bus.dbus_req), 0);
        check("rst_halt", 32'(mau_halt), 0);
        check("rst_fault", 32'(mau_fault), 0);
        check("rst_data", mau_data, 0);
        check("rst_addr", bus.dbus_addr, 0);
        rst = 1'b1;
        step();

        // load 0x100, ack after 3 wait cycles
        req_ld = 1; req_addr = 32'h100;
        push(0, 0, 0, 32'hDEADBEEF); model_data = 32'hDEADBEEF;
        step();
        req_ld = 0;
        for (int i = 0; i < 4; i++) begin
            check("ld_req_hi", 32'(bus.dbus_req), 1);
            check("ld_halt_hi", 32'(mau_halt), 1);
            if (i == 3) begin bus.dbus_ack = 1; bus.dbus_rdata = 32'hDEADBEEF; end
            step();
        end
        bus.dbus_ack = 0;
        check("ld_req_lo", 32'(bus.dbus_req), 0);
        check("ld_halt_lo", 32'(mau_halt), 0);
        check("ld_data", mau_data, 32'hDEADBEEF);

        // store 0x204 zero-wait, then load straight from DONE
        req_st = 1; req_addr = 32'h204; req_wdata = 32'h12345678;
        push(0, 0, 0, model_data);
        step();
        req_st = 0;
        check("st_req", 32'(bus.dbus_req), 1);
        check("st_we", 32'(bus.dbus_we), 1);
        check("st_addr", bus.dbus_addr, 32'h204);
        check("st_wdata", bus.dbus_wdata, 32'h12345678);
        bus.dbus_ack = 1; bus.dbus_rdata = 32'hFFFF0000;
        step();
        bus.dbus_ack = 0;
        check("st_data_kept", mau_data, 32'hDEADBEEF);
        req_ld = 1; req_addr = 32'h208;
        push(0, 0, 0, 32'hCAFEF00D); model_data = 32'hCAFEF00D;
        step();
        req_ld = 0;
        check("b2b_req", 32'(bus.dbus_req), 1);
        check("b2b_we", 32'(bus.dbus_we), 0);
        check("b2b_addr", bus.dbus_addr, 32'h208);
        bus.dbus_ack = 1; bus.dbus_rdata = 32'hCAFEF00D;
        step();
        bus.dbus_ack = 0;
        check("b2b_data", mau_data, 32'hCAFEF00D);

        // misaligned load
        req_ld = 1; req_addr = 32'h102;
        push(1, 2'd1, 32'h102, model_data);
        step();
        req_ld = 0;
        check("mis_fault", 32'(mau_fault), 1);
        check("mis_req", 32'(bus.dbus_req), 0);
        check("mis_halt", 32'(mau_halt), 0);
        check("mis_cause", 32'(mau_fault_cause), 1);
        check("mis_faddr", mau_fault_addr, 32'h102);
        step();
        check("mis_pulse", 32'(mau_fault), 0);

        // err and ack together
        req_ld = 1; req_addr = 32'h300;
        push(1, 2'd2, 32'h300, model_data);
        step();
        req_ld = 0;
        bus.dbus_err = 1; bus.dbus_ack = 1; bus.dbus_rdata = 32'hBAD0BAD0;
        step();
        bus.dbus_err = 0; bus.dbus_ack = 0;
        check("err_cause", 32'(mau_fault_cause), 2);
        check("err_data", mau_data, 32'hCAFEF00D);
        step();

        // timeout with TIMEOUT=4
        req_ld = 1; req_addr = 32'h400;
        push(1, 2'd3, 32'h400, model_data);
        step();
        req_ld = 0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_req_hi", 32'(bus.dbus_req), 1);
            step();
        end
        check("tmo_req_lo", 32'(bus.dbus_req), 0);
        check("tmo_fault", 32'(mau_fault), 1);
        check("tmo_cause", 32'(mau_fault_cause), 3);
        step();

        // stall and flush suppress acceptance
        req_ld = 1; req_addr = 32'h500; stall = 1;
        step();
        check("stall_halt", 32'(mau_halt), 0);
        stall = 0; flush = 1;
        step();
        check("flush_idle_req", 32'(bus.dbus_req), 0);
        flush = 0;

        // flush during BUSY, ack two cycles later
        push(0, 0, 0, model_data);
        step();
        req_ld = 0; flush = 1;
        step();
        flush = 0;
        step();
        bus.dbus_ack = 1; bus.dbus_rdata = 32'h55;
        step();
        bus.dbus_ack = 0;
        check("fl_data", mau_data, 32'hCAFEF00D);
        check("fl_fault", 32'(mau_fault), 0);
        check("fl_halt", 32'(mau_halt), 0);
        step();
        check("fl_fault2", 32'(mau_fault), 0);
        check("fl_sb_empty", 32'(sb.size()), 0);

        // async reset mid-BUSY
        req_ld = 1; req_addr = 32'h600;
        step();
        req_ld = 0;
        check("ar_busy", 32'(mau_halt), 1);
        #2 rst = 1'b0;
        #1;
        check("ar_req", 32'(bus.dbus_req), 0);
        check("ar_halt", 32'(mau_halt), 0);
        check("ar_addr", bus.dbus_addr, 0);
        check("ar_data", mau_data, 0);
        check("ar_faddr", mau_fault_addr, 0);
        step();
        rst = 1'b1;
        step(); step();
        check("end_sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
